// File: rtl/cpu_stage_sequencer.sv
// cpu_stage_sequencer
// Walks the SM5xx core through fetch / optional second fetch / execute /
// PC+RAM-address commit for each instruction, and owns the skip and
// CEND halt/wake control flow requested by the instruction tasks.
// Every strobe is registered on the clk_en edge of the stage that issues
// it, so it is high for exactly one clk cycle after that edge.
module cpu_stage_sequencer #(
    parameter logic [3:0] LAX_OPCODE_HI = 4'h2,
    parameter logic [2:0] RESET_STAGE   = 3'd0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk_en,
    input  logic [7:0] rom_data,
    input  logic       is_two_byte,
    input  logic       skip_req,
    input  logic       skip_if_lax_req,
    input  logic       halt_req,
    input  logic       wake,
    output logic [2:0] stage,
    output logic [7:0] opcode,
    output logic [7:0] operand,
    output logic [7:0] last_opcode,
    output logic       pc_inc,
    output logic       exec_en,
    output logic       commit,
    output logic       halted,
    output logic       skipping
);

    localparam logic [2:0] ST_FETCH   = 3'd0;
    localparam logic [2:0] ST_FETCH2  = 3'd1;
    localparam logic [2:0] ST_EXECUTE = 3'd2;
    localparam logic [2:0] ST_LOAD_PC = 3'd3;
    localparam logic [2:0] ST_HALT    = 3'd4;

    logic [2:0] r_stage;
    logic [2:0] w_stage_next;
    logic [7:0] r_opcode;
    logic [7:0] r_operand;
    logic [7:0] r_last_opcode;
    logic       r_skipping;
    logic       r_skip_pending;
    logic       r_lax_pending;
    logic       r_halt_latched;
    logic       r_pc_inc;
    logic       r_exec_en;
    logic       r_commit;
    logic       w_pc_inc_next;
    logic       w_exec_en_next;
    logic       w_commit_next;
    logic       w_lax_match;
    logic       w_skip;

    // A pending LAX skip only applies when the fetched opcode is itself a LAX.
    assign w_lax_match = (rom_data[7:4] == LAX_OPCODE_HI);
    assign w_skip      = r_skip_pending | (r_lax_pending & w_lax_match);

    // Stage register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stage <= RESET_STAGE;
        end else begin
            r_stage <= w_stage_next;
        end
    end

    // Next-stage decode; nothing moves without a CPU tick.
    always_comb begin
        w_stage_next = r_stage;
        if (clk_en) begin
            case (r_stage)
                ST_FETCH:   w_stage_next = is_two_byte ? ST_FETCH2 : ST_EXECUTE;
                ST_FETCH2:  w_stage_next = ST_EXECUTE;
                ST_EXECUTE: w_stage_next = ST_LOAD_PC;
                ST_LOAD_PC: w_stage_next = r_halt_latched ? ST_HALT : ST_FETCH;
                ST_HALT:    w_stage_next = wake ? ST_FETCH : ST_HALT;
                default:    w_stage_next = ST_FETCH;
            endcase
        end
    end

    // Strobe decode for the stage acting on this tick; skipped instructions never execute.
    always_comb begin
        w_pc_inc_next  = clk_en && ((r_stage == ST_FETCH) || (r_stage == ST_FETCH2));
        w_exec_en_next = clk_en && (r_stage == ST_EXECUTE) && !r_skipping;
        w_commit_next  = clk_en && (r_stage == ST_LOAD_PC);
    end

    // Strobe registers: one-cycle pulses following the issuing tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc_inc  <= 1'b0;
            r_exec_en <= 1'b0;
            r_commit  <= 1'b0;
        end else begin
            r_pc_inc  <= w_pc_inc_next;
            r_exec_en <= w_exec_en_next;
            r_commit  <= w_commit_next;
        end
    end

    // Instruction bytes and skip/halt bookkeeping; pending skips survive HALT untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_opcode       <= 8'h00;
            r_operand      <= 8'h00;
            r_last_opcode  <= 8'h00;
            r_skipping     <= 1'b0;
            r_skip_pending <= 1'b0;
            r_lax_pending  <= 1'b0;
            r_halt_latched <= 1'b0;
        end else if (clk_en) begin
            case (r_stage)
                ST_FETCH: begin
                    r_opcode       <= rom_data;
                    r_skipping     <= w_skip;
                    r_skip_pending <= 1'b0;
                    r_lax_pending  <= 1'b0;
                    if (!is_two_byte) begin
                        r_operand <= 8'h00;
                    end
                end
                ST_FETCH2: begin
                    r_operand <= rom_data;
                end
                ST_EXECUTE: begin
                    // A skipped instruction cannot request anything of its own.
                    r_skip_pending <= skip_req & ~r_skipping;
                    r_lax_pending  <= skip_if_lax_req & ~r_skipping;
                    r_halt_latched <= halt_req & ~r_skipping;
                    if (!r_skipping) begin
                        r_last_opcode <= r_opcode;
                    end
                end
                ST_LOAD_PC: begin
                    r_skipping     <= 1'b0;
                    r_halt_latched <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign stage       = r_stage;
    assign opcode      = r_opcode;
    assign operand     = r_operand;
    assign last_opcode = r_last_opcode;
    assign pc_inc      = r_pc_inc;
    assign exec_en     = r_exec_en;
    assign commit      = r_commit;
    assign halted      = (r_stage == ST_HALT);
    assign skipping    = r_skipping;

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Directed-vector bench for cpu_stage_sequencer: a table of per-cycle
// inputs and hand-computed outputs, plus hand-written reset sequences.
module tb_cpu_stage_sequencer;

    logic       clk;
    logic       reset_n;
    logic       clk_en;
    logic [7:0] rom_data;
    logic       is_two_byte;
    logic       skip_req;
    logic       skip_if_lax_req;
    logic       halt_req;
    logic       wake;
    logic [2:0] stage;
    logic [7:0] opcode;
    logic [7:0] operand;
    logic [7:0] last_opcode;
    logic       pc_inc;
    logic       exec_en;
    logic       commit;
    logic       halted;
    logic       skipping;

    cpu_stage_sequencer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .clk_en          (clk_en),
        .rom_data        (rom_data),
        .is_two_byte     (is_two_byte),
        .skip_req        (skip_req),
        .skip_if_lax_req (skip_if_lax_req),
        .halt_req        (halt_req),
        .wake            (wake),
        .stage           (stage),
        .opcode          (opcode),
        .operand         (operand),
        .last_opcode     (last_opcode),
        .pc_inc          (pc_inc),
        .exec_en         (exec_en),
        .commit          (commit),
        .halted          (halted),
        .skipping        (skipping)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         reps;
        logic       en;
        logic [7:0] rom;
        logic       two;
        logic       skp;
        logic       lax;
        logic       hlt;
        logic       wk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_err;

    // Packed view of all outputs: stage, opcode, operand, last_opcode, pc_inc, exec_en, commit, halted, skipping.
    function automatic logic [31:0] pack(input logic [2:0] st, input logic [7:0] op,
                                         input logic [7:0] opd, input logic [7:0] last,
                                         input logic pi, input logic ex, input logic cm,
                                         input logic h, input logic sk);
        return {st, op, opd, last, pi, ex, cm, h, sk};
    endfunction

    function automatic logic [31:0] actual();
        return pack(stage, opcode, operand, last_opcode, pc_inc, exec_en, commit, halted, skipping);
    endfunction

    task automatic check(input string name, input logic [31:0] want);
        logic [31:0] got;
        got = actual();
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got st=%0d op=%h opd=%h last=%h pi/ex/cm/h/sk=%b  want st=%0d op=%h opd=%h last=%h pi/ex/cm/h/sk=%b",
                     name, got[31:29], got[28:21], got[20:13], got[12:5], got[4:0],
                     want[31:29], want[28:21], want[20:13], want[12:5], want[4:0]);
        end
    endtask

    task automatic v(input int reps, input logic en, input logic [7:0] rom, input logic two,
                     input logic skp, input logic lax, input logic hlt, input logic wk,
                     input logic [2:0] st, input logic [7:0] op, input logic [7:0] opd,
                     input logic [7:0] last, input logic pi, input logic ex, input logic cm,
                     input logic h, input logic sk);
        vec_t t;
        t.reps = reps; t.en = en; t.rom = rom; t.two = two;
        t.skp = skp; t.lax = lax; t.hlt = hlt; t.wk = wk;
        t.exp = pack(st, op, opd, last, pi, ex, cm, h, sk);
        vecs.push_back(t);
    endtask

    task automatic set_idle();
        clk_en = 1'b0; rom_data = 8'h00; is_two_byte = 1'b0;
        skip_req = 1'b0; skip_if_lax_req = 1'b0; halt_req = 1'b0; wake = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        set_idle();
        reset_n = 1'b0;

        //  reps en rom  two skp lax hlt wk | st op    opd   last  pi ex cm h sk
        // one-byte 0x4C after reset
        v(1, 1, 8'h4C, 0, 0, 0, 0, 0,   2, 8'h4C, 8'h00, 8'h00, 1, 0, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   3, 8'h4C, 8'h00, 8'h4C, 0, 1, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   0, 8'h4C, 8'h00, 8'h4C, 0, 0, 1, 0, 0);
        // two-byte 0x70 0x35
        v(1, 1, 8'h70, 1, 0, 0, 0, 0,   1, 8'h70, 8'h00, 8'h4C, 1, 0, 0, 0, 0);
        v(1, 1, 8'h35, 0, 0, 0, 0, 0,   2, 8'h70, 8'h35, 8'h4C, 1, 0, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   3, 8'h70, 8'h35, 8'h70, 0, 1, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   0, 8'h70, 8'h35, 8'h70, 0, 0, 1, 0, 0);
        // 0x5A requests a skip of the next instruction
        v(1, 1, 8'h5A, 0, 0, 0, 0, 0,   2, 8'h5A, 8'h00, 8'h70, 1, 0, 0, 0, 0);
        v(1, 1, 8'h00, 0, 1, 0, 0, 0,   3, 8'h5A, 8'h00, 8'h5A, 0, 1, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   0, 8'h5A, 8'h00, 8'h5A, 0, 0, 1, 0, 0);
        // skipped two-byte 0x70 0x12: its own requests are ignored
        v(1, 1, 8'h70, 1, 0, 0, 0, 0,   1, 8'h70, 8'h00, 8'h5A, 1, 0, 0, 0, 1);
        v(1, 1, 8'h12, 0, 0, 0, 0, 0,   2, 8'h70, 8'h12, 8'h5A, 1, 0, 0, 0, 1);
        v(1, 1, 8'h00, 0, 1, 1, 1, 0,   3, 8'h70, 8'h12, 8'h5A, 0, 0, 0, 0, 1);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   0, 8'h70, 8'h12, 8'h5A, 0, 0, 1, 0, 0);
        v(1, 1, 8'h33, 0, 0, 0, 0, 0,   2, 8'h33, 8'h00, 8'h5A, 1, 0, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   3, 8'h33, 8'h00, 8'h33, 0, 1, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   0, 8'h33, 8'h00, 8'h33, 0, 0, 1, 0, 0);
        // LAX chain 0x25 / 0x27 / 0x29
        v(1, 1, 8'h25, 0, 0, 0, 0, 0,   2, 8'h25, 8'h00, 8'h33, 1, 0, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 1, 0, 0,   3, 8'h25, 8'h00, 8'h25, 0, 1, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   0, 8'h25, 8'h00, 8'h25, 0, 0, 1, 0, 0);
        v(1, 1, 8'h27, 0, 0, 0, 0, 0,   2, 8'h27, 8'h00, 8'h25, 1, 0, 0, 0, 1);
        v(1, 1, 8'h00, 0, 0, 1, 0, 0,   3, 8'h27, 8'h00, 8'h25, 0, 0, 0, 0, 1);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   0, 8'h27, 8'h00, 8'h25, 0, 0, 1, 0, 0);
        v(1, 1, 8'h29, 0, 0, 0, 0, 0,   2, 8'h29, 8'h00, 8'h25, 1, 0, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   3, 8'h29, 8'h00, 8'h29, 0, 1, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   0, 8'h29, 8'h00, 8'h29, 0, 0, 1, 0, 0);
        // LAX request followed by a non-LAX opcode: no skip, request consumed
        v(1, 1, 8'h40, 0, 0, 0, 0, 0,   2, 8'h40, 8'h00, 8'h29, 1, 0, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 1, 0, 0,   3, 8'h40, 8'h00, 8'h40, 0, 1, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   0, 8'h40, 8'h00, 8'h40, 0, 0, 1, 0, 0);
        v(1, 1, 8'h51, 0, 0, 0, 0, 0,   2, 8'h51, 8'h00, 8'h40, 1, 0, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   3, 8'h51, 8'h00, 8'h51, 0, 1, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   0, 8'h51, 8'h00, 8'h51, 0, 0, 1, 0, 0);
        v(1, 1, 8'h26, 0, 0, 0, 0, 0,   2, 8'h26, 8'h00, 8'h51, 1, 0, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   3, 8'h26, 8'h00, 8'h26, 0, 1, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   0, 8'h26, 8'h00, 8'h26, 0, 0, 1, 0, 0);
        // halt together with skip, then wake
        v(1, 1, 8'h60, 0, 0, 0, 0, 0,   2, 8'h60, 8'h00, 8'h26, 1, 0, 0, 0, 0);
        v(1, 1, 8'h00, 0, 1, 0, 1, 0,   3, 8'h60, 8'h00, 8'h60, 0, 1, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 0, 0, 1,   4, 8'h60, 8'h00, 8'h60, 0, 0, 1, 1, 0);
        v(5, 1, 8'h00, 0, 0, 0, 0, 0,   4, 8'h60, 8'h00, 8'h60, 0, 0, 0, 1, 0);
        v(1, 0, 8'h00, 0, 0, 0, 0, 1,   4, 8'h60, 8'h00, 8'h60, 0, 0, 0, 1, 0);
        v(1, 1, 8'h00, 0, 0, 0, 0, 1,   0, 8'h60, 8'h00, 8'h60, 0, 0, 0, 0, 0);
        v(1, 1, 8'h61, 0, 0, 0, 0, 0,   2, 8'h61, 8'h00, 8'h60, 1, 0, 0, 0, 1);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   3, 8'h61, 8'h00, 8'h60, 0, 0, 0, 0, 1);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   0, 8'h61, 8'h00, 8'h60, 0, 0, 1, 0, 0);
        v(1, 1, 8'h62, 0, 0, 0, 0, 0,   2, 8'h62, 8'h00, 8'h60, 1, 0, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   3, 8'h62, 8'h00, 8'h62, 0, 1, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   0, 8'h62, 8'h00, 8'h62, 0, 0, 1, 0, 0);
        // clk_en low for 10 cycles in every stage of a two-byte instruction
        v(10, 0, 8'hAA, 1, 1, 1, 1, 1,  0, 8'h62, 8'h00, 8'h62, 0, 0, 0, 0, 0);
        v(1, 1, 8'h7E, 1, 0, 0, 0, 0,   1, 8'h7E, 8'h00, 8'h62, 1, 0, 0, 0, 0);
        v(10, 0, 8'h55, 0, 0, 0, 0, 0,  1, 8'h7E, 8'h00, 8'h62, 0, 0, 0, 0, 0);
        v(1, 1, 8'h44, 0, 0, 0, 0, 0,   2, 8'h7E, 8'h44, 8'h62, 1, 0, 0, 0, 0);
        v(10, 0, 8'h00, 0, 1, 1, 1, 0,  2, 8'h7E, 8'h44, 8'h62, 0, 0, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   3, 8'h7E, 8'h44, 8'h7E, 0, 1, 0, 0, 0);
        v(10, 0, 8'h00, 0, 0, 0, 0, 1,  3, 8'h7E, 8'h44, 8'h7E, 0, 0, 0, 0, 0);
        v(1, 1, 8'h00, 0, 0, 0, 0, 0,   0, 8'h7E, 8'h44, 8'h7E, 0, 0, 1, 0, 0);
        v(1, 1, 8'h01, 0, 0, 0, 0, 0,   2, 8'h01, 8'h00, 8'h7E, 1, 0, 0, 0, 0);

        // Reset state, then an instruction interrupted by reset in EXECUTE.
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", pack(3'd0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0));
        reset_n = 1'b1;
        clk_en = 1'b1; rom_data = 8'h11;
        @(posedge clk); #1;
        check("pre_reset_fetch", pack(3'd2, 8'h11, 8'h00, 8'h00, 1, 0, 0, 0, 0));
        set_idle();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_mid_execute", pack(3'd0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0));
        clk_en = 1'b1; rom_data = 8'h99;
        @(posedge clk); #1;
        check("held_in_reset", pack(3'd0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0));
        set_idle();
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                clk_en          = vecs[i].en;
                rom_data        = vecs[i].rom;
                is_two_byte     = vecs[i].two;
                skip_req        = vecs[i].skp;
                skip_if_lax_req = vecs[i].lax;
                halt_req        = vecs[i].hlt;
                wake            = vecs[i].wk;
                @(posedge clk); #1;
                check($sformatf("vec%0d_rep%0d", i, r), vecs[i].exp);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_stage_sequencer.md
# cpu_stage_sequencer

Sequences the SM5xx CPU core through its per-instruction micro-stages: fetch, optional second-byte fetch, execute, and PC/RAM-address commit. It owns the skip/halt control flow the instruction tasks request. It sits between the program ROM and the instruction task block, and produces the strobes that gate instruction execution, PC increment and deferred RAM-address writes. It handles one-byte and two-byte opcodes, conditional skips (including the LAX-chain skip) and CEND halt/wake.

## Interface
Parameters:
- LAX_OPCODE_HI, 4'h2, high nibble identifying LAX for the chained-LAX skip
- RESET_STAGE, 3'd0, stage entered on reset (FETCH)

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous assert, active-low
- clk_en  in  1  CPU tick; the FSM advances only on cycles with clk_en=1
- rom_data  in  8  ROM byte at current PC, valid in the cycle clk_en samples it
- is_two_byte  in  1  decoder flag for rom_data as a first byte; valid in FETCH
- skip_req  in  1  skip_next_instr from the execute tasks; sampled in EXECUTE
- skip_if_lax_req  in  1  skip_next_if_lax; sampled in EXECUTE
- halt_req  in  1  CEND; sampled in EXECUTE
- wake  in  1  level: any K input high or 1 s tick
- stage  out  3  FETCH=0, FETCH2=1, EXECUTE=2, LOAD_PC=3, HALT=4
- opcode  out  8  current first byte
- operand  out  8  second byte; 0 for one-byte opcodes
- last_opcode  out  8  opcode of the last executed (not skipped) instruction
- pc_inc  out  1  one-cycle strobe: increment Pl
- exec_en  out  1  one-cycle strobe: run instruction task
- commit  out  1  one-cycle strobe: apply next_ram_addr, clear temp_sbm
- halted  out  1  high while in HALT
- skipping  out  1  high while the current instruction is being skipped

## Operation
- **Reset.** While reset_n=0: stage=FETCH; opcode, operand and last_opcode are 0; all strobes are 0; halted=0; skipping=0; the internal skip_pending and lax_pending bits are 0. Reset assertion mid-instruction aborts that instruction immediately.
- **FETCH** (on clk_en):
  - latch opcode←rom_data and pulse pc_inc;
  - compute skip = skip_pending | (lax_pending & rom_data[7:4]==LAX_OPCODE_HI);
  - set skipping←skip; clear skip_pending and lax_pending;
  - if is_two_byte, go to FETCH2; otherwise set operand←0 and go to EXECUTE.
- **FETCH2** (on clk_en): operand←rom_data, pulse pc_inc, go to EXECUTE. A skipped two-byte opcode still consumes both bytes.
- **EXECUTE** (on clk_en):
  - if !skipping: pulse exec_en and set last_opcode←opcode;
  - if skipping: no exec_en; last_opcode unchanged; skip_req, skip_if_lax_req and halt_req are ignored;
  - latch skip_pending←skip_req and lax_pending←skip_if_lax_req, each gated by !skipping;
  - go to LOAD_PC.
- **LOAD_PC** (on clk_en):
  - pulse commit; clear skipping;
  - go to HALT if a halt was latched in EXECUTE, otherwise go to FETCH.
- **HALT:**
  - halted=1 and no strobes;
  - on clk_en with wake=1, go to FETCH and clear halted;
  - skip_pending and lax_pending are preserved across HALT.
- **Simultaneous requests.**
  - halt_req together with skip_req: halt is taken; the skip applies to the first instruction after wake.
  - skip_req together with skip_if_lax_req: both bits are latched; skip_pending dominates.
- **Wrap-around** of Pl is not this block's concern; pc_inc is only a strobe.

## Timing
- All strobes are single-cycle pulses, registered, and asserted in the cycle following the clk_en edge that enters the stage.
- One-byte instruction: 3 clk_en ticks (FETCH, EXECUTE, LOAD_PC). Two-byte instruction: 4 ticks.
- With clk_en held high, the strobe pattern repeats every 3 (or 4) clk cycles.
- exec_en precedes commit by exactly one clk_en tick.
- rom_data must reflect the incremented PC by the next clk_en after pc_inc.
- wake is sampled only on clk_en. Minimum HALT residency is 1 tick.
- Reset release: the first clk_en fetches from the current PC. The sequencer does not reset the PC.

## Test plan
- **Reset mid-EXECUTE.** Assert reset_n=0 during EXECUTE → stage=0, all outputs 0 asynchronously. Release, run opcode 0x4C → sequence FETCH/EXECUTE/LOAD_PC; exec_en on the second tick; last_opcode=0x4C.
- **Two-byte instruction.** rom_data=0x70 then 0x35, with is_two_byte=1 → operand=0x35, two pc_inc pulses, one exec_en, 4 ticks total.
- **Skip of a two-byte instruction.** skip_req=1 in EXECUTE, next opcode 0x70/0x12 (two-byte) → both bytes consumed, no exec_en, last_opcode holds the prior value, following instruction executes normally.
- **LAX chain.** Opcodes 0x25, 0x27, 0x29 with skip_if_lax_req=1 during the first → 0x27 skipped. 0x29 is executed because skip_if_lax_req is ignored for skipped instructions.
- **Halt and wake.** halt_req=1 with skip_req=1 → HALT after commit; halted=1 for 5 ticks with wake=0; wake=1 → FETCH; first post-wake instruction skipped, second executed.
- **Idle clock enable.** clk_en=0 for 10 cycles in each stage → stage frozen, no strobes.
